// File: rtl/bcd_score_counter_n_if.sv
// Score-path bundle between game logic (master) and the BCD score counter (slave).
interface bcd_score_counter_n_if #(
  parameter int DIGITS = 3
);
  logic                  clear;
  logic                  hi_clear;
  logic                  inc;
  logic [4*DIGITS-1:0]   score;
  logic [4*DIGITS-1:0]   hi_score;
  logic                  overflow;
  logic                  new_high;

  modport master (
    output clear, hi_clear, inc,
    input  score, hi_score, overflow, new_high
  );

  modport slave (
    input  clear, hi_clear, inc,
    output score, hi_score, overflow, new_high
  );
endinterface

// File: rtl/bcd_score_counter_n.sv
// N-digit BCD score counter with saturate/wrap overflow policy, optional
// rising-edge qualification of inc, and a persistent high-score register.
module bcd_score_counter_n #(
  parameter int DIGITS    = 3,
  parameter int WRAP_MODE = 0,
  parameter int EDGE_DET  = 1
) (
  input logic                 clk,
  input logic                 reset,
  bcd_score_counter_n_if.slave sif
);
  localparam int W = 4 * DIGITS;

  logic [W-1:0] score_q, score_d;
  logic [W-1:0] hi_q, hi_d;
  logic         ovf_q, ovf_d;
  logic         new_high_q, new_high_d;
  logic         inc_prev_q;

  logic         inc_q;
  logic         all_nines;
  logic         carry;
  logic [3:0]   dig;
  logic [W-1:0] inc_val;

  always_comb begin
    inc_q      = (EDGE_DET != 0) ? (sif.inc & ~inc_prev_q) : sif.inc;
    all_nines  = 1'b1;
    carry      = 1'b1;
    dig        = 4'd0;
    inc_val    = score_q;
    score_d    = score_q;
    ovf_d      = ovf_q;
    hi_d       = hi_q;
    new_high_d = 1'b0;

    // Ripple the +1 through every digit in one cycle; a 9 with carry-in rolls to 0.
    for (int k = 0; k < DIGITS; k++) begin
      dig = score_q[4*k +: 4];
      if (dig != 4'd9) all_nines = 1'b0;
      if (carry) begin
        if (dig == 4'd9) begin
          inc_val[4*k +: 4] = 4'd0;
        end else begin
          inc_val[4*k +: 4] = dig + 4'd1;
          carry = 1'b0;
        end
      end
    end

    if (sif.clear) begin
      score_d = '0;
      ovf_d   = 1'b0;
    end else if (inc_q) begin
      if (all_nines) begin
        ovf_d   = 1'b1;
        score_d = (WRAP_MODE != 0) ? '0 : score_q;
      end else begin
        score_d = inc_val;
      end
    end

    // Valid BCD orders the same as plain binary, so a raw compare is numeric.
    if (sif.hi_clear) begin
      hi_d = '0;
    end else if (score_q > hi_q) begin
      hi_d       = score_q;
      new_high_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      score_q    <= '0;
      hi_q       <= '0;
      ovf_q      <= 1'b0;
      new_high_q <= 1'b0;
      inc_prev_q <= 1'b0;
    end else begin
      score_q    <= score_d;
      hi_q       <= hi_d;
      ovf_q      <= ovf_d;
      new_high_q <= new_high_d;
      inc_prev_q <= sif.inc;
    end
  end

  assign sif.score    = score_q;
  assign sif.hi_score = hi_q;
  assign sif.overflow = ovf_q;
  assign sif.new_high = new_high_q;
endmodule

// File: tb/tb_bcd_score_counter_n.sv
// Scoreboard bench: three counter variants (saturate/edge, wrap/edge, saturate/level)
// share one stimulus stream and are checked against an integer-arithmetic model.
module tb_bcd_score_counter_n;
  localparam int NDUT = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr_s = 1'b0, hclr_s = 1'b0, inc_s = 1'b0;

  always #5 clk = ~clk;

  bcd_score_counter_n_if #(.DIGITS(3)) if0 ();
  bcd_score_counter_n_if #(.DIGITS(3)) if1 ();
  bcd_score_counter_n_if #(.DIGITS(3)) if2 ();

  assign if0.clear = clr_s;  assign if0.hi_clear = hclr_s;  assign if0.inc = inc_s;
  assign if1.clear = clr_s;  assign if1.hi_clear = hclr_s;  assign if1.inc = inc_s;
  assign if2.clear = clr_s;  assign if2.hi_clear = hclr_s;  assign if2.inc = inc_s;

  bcd_score_counter_n #(.DIGITS(3), .WRAP_MODE(0), .EDGE_DET(1)) u_sat  (.clk(clk), .reset(rst), .sif(if0));
  bcd_score_counter_n #(.DIGITS(3), .WRAP_MODE(1), .EDGE_DET(1)) u_wrap (.clk(clk), .reset(rst), .sif(if1));
  bcd_score_counter_n #(.DIGITS(3), .WRAP_MODE(0), .EDGE_DET(0)) u_lvl  (.clk(clk), .reset(rst), .sif(if2));

  logic [11:0] sc_w [NDUT];
  logic [11:0] hi_w [NDUT];
  logic        ov_w [NDUT];
  logic        nh_w [NDUT];
  assign sc_w[0] = if0.score; assign hi_w[0] = if0.hi_score; assign ov_w[0] = if0.overflow; assign nh_w[0] = if0.new_high;
  assign sc_w[1] = if1.score; assign hi_w[1] = if1.hi_score; assign ov_w[1] = if1.overflow; assign nh_w[1] = if1.new_high;
  assign sc_w[2] = if2.score; assign hi_w[2] = if2.hi_score; assign ov_w[2] = if2.overflow; assign nh_w[2] = if2.new_high;

  typedef struct packed {
    logic [11:0] sc;
    logic [11:0] hi;
    logic        ovf;
    logic        nh;
  } exp_t;

  exp_t sb[$];

  const bit m_wrap [NDUT] = '{1'b0, 1'b1, 1'b0};
  const bit m_edge [NDUT] = '{1'b1, 1'b1, 1'b0};
  int m_sc [NDUT];
  int m_hi [NDUT];
  bit m_ovf [NDUT];
  bit m_nh [NDUT];
  bit m_prev [NDUT];

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    to_bcd = {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic bit bad_digit(input logic [11:0] v);
    bad_digit = (v[3:0] > 4'd9) || (v[7:4] > 4'd9) || (v[11:8] > 4'd9);
  endfunction

  function automatic string nm(input string base, input int k);
    nm = $sformatf("%s[%0d]", base, k);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NDUT; k++) begin
      m_sc[k] = 0; m_hi[k] = 0; m_ovf[k] = 1'b0; m_nh[k] = 1'b0; m_prev[k] = 1'b0;
    end
  endtask

  // One clock cycle: drive, predict into the scoreboard, then pop and compare after the edge.
  task automatic cyc(input bit c, input bit h, input bit i);
    exp_t e;
    bit   q;
    clr_s = c; hclr_s = h; inc_s = i;
    for (int k = 0; k < NDUT; k++) begin
      q = m_edge[k] ? (i && !m_prev[k]) : i;
      m_prev[k] = i;
      if (h) begin
        m_hi[k] = 0; m_nh[k] = 1'b0;
      end else if (m_sc[k] > m_hi[k]) begin
        m_hi[k] = m_sc[k]; m_nh[k] = 1'b1;
      end else begin
        m_nh[k] = 1'b0;
      end
      if (c) begin
        m_sc[k] = 0; m_ovf[k] = 1'b0;
      end else if (q) begin
        if (m_sc[k] == 999) begin
          m_ovf[k] = 1'b1;
          if (m_wrap[k]) m_sc[k] = 0;
        end else begin
          m_sc[k] = m_sc[k] + 1;
        end
      end
      e.sc = to_bcd(m_sc[k]); e.hi = to_bcd(m_hi[k]); e.ovf = m_ovf[k]; e.nh = m_nh[k];
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      e = sb.pop_front();
      check(nm("score", k), 32'(sc_w[k]), 32'(e.sc));
      check(nm("hi_score", k), 32'(hi_w[k]), 32'(e.hi));
      check(nm("overflow", k), 32'(ov_w[k]), 32'(e.ovf));
      check(nm("new_high", k), 32'(nh_w[k]), 32'(e.nh));
      check(nm("digit_le9", k), 32'(bad_digit(sc_w[k])), 32'd0);
    end
  endtask

  task automatic pulse(input int n);
    for (int j = 0; j < n; j++) begin
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < NDUT; k++) begin
      check(nm({tag, "_score"}, k), 32'(sc_w[k]), 32'd0);
      check(nm({tag, "_hi"}, k), 32'(hi_w[k]), 32'd0);
      check(nm({tag, "_ovf"}, k), 32'(ov_w[k]), 32'd0);
      check(nm({tag, "_nh"}, k), 32'(nh_w[k]), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #12;
    check_all_zero("por");
    @(negedge clk);
    rst = 1'b1;

    // 1: reach 437, then drop reset between edges
    pulse(437);
    check(nm("pre_rst_score", 0), 32'(sc_w[0]), 32'h437);
    #3 rst = 1'b0;
    #1 check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int j = 0; j < 5; j++) cyc(1'b0, 1'b0, 1'b0);

    // 2: held inc vs edge detection
    for (int j = 0; j < 10; j++) cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    pulse(3);

    // 3: carry chain 099->100, 199->200
    cyc(1'b1, 1'b0, 1'b0);
    pulse(99);
    pulse(1);
    pulse(99);
    pulse(1);

    // 4: run to 999 and one beyond, then clear
    while (m_sc[0] != 999) pulse(1);
    pulse(1);
    check(nm("wrap_hi_kept", 1), 32'(hi_w[1]), 32'h999);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);

    // 5: high-score tracking
    cyc(1'b0, 1'b1, 1'b0);
    pulse(25);
    cyc(1'b1, 1'b0, 1'b0);
    pulse(12);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);

    // 6: simultaneous events
    cyc(1'b1, 1'b0, 1'b0);
    pulse(50);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    pulse(3);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);

    // inc already high across reset release counts once on edge-detect variants
    inc_s = 1'b1;
    #3 rst = 1'b0;
    #1 check_all_zero("rst_hold_inc");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int j = 0; j < 4; j++) cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
